regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port among N writeback sources (ALU, load unit, multiply/divide) with round-robin arbitration and a valid/ready handshake. It also keeps a 32-entry pending-write scoreboard that decode uses for hazard stalls. It sits between the execute/memory stages and the register file, driving the file's write-enable, destination and data inputs from registered outputs.

## Interface
- N_REQ, 3: number of writeback requesters (2..8)
- XLEN, 64: data width
- clk_i  input  1  clock; all state updates on posedge
- rst_i  input  1  reset, synchronous, active-high
- req_valid_i  input  N_REQ  requester i has a write pending
- req_dest_i  input  N_REQ x 5  destination register per requester
- req_data_i  input  N_REQ x XLEN  write data per requester
- req_ready_o  output  N_REQ  one-hot grant; request i accepted this cycle
- reserve_i  input  1  decode issues an instruction that will write reserve_dest_i
- reserve_dest_i  input  5  register being reserved
- flush_i  input  1  pipeline flush; clears the scoreboard
- wr_reg_en_o  output  1  register file write enable
- wr_reg_dest_o  output  5  register file write destination
- wr_reg_data_o  output  XLEN  register file write data
- busy_o  output  32  bit r set means a write to xr is outstanding

## Operation
- Arbitration is combinational:
  - Among requesters with valid high, grant the first one found, searching from index rr_ptr+1 upward with wrap-around.
  - At most one req_ready_o bit is high.
  - req_ready_o is all-zero when no valid is high or rst_i is high.
- Handshake:
  - A transfer occurs when valid[i] && ready[i].
  - A requester must hold valid, dest and data stable until the transfer.
  - ready never depends on a later cycle.
- rr_ptr updates to the granted index on every transfer and holds otherwise. Reset value is N_REQ-1, so requester 0 has top priority first.
- Write register stage:
  - On a transfer, wr_reg_en_o <= (dest != 0), and dest/data are latched.
  - With no transfer, wr_reg_en_o <= 0, and dest/data hold their previous values.
  - A transfer with dest 0 is accepted and discarded: no write, no busy change.
- Scoreboard busy_r[31:0]:
  - Set bit d on reserve_i with d != 0.
  - Clear bit d when wr_reg_en_o is high with wr_reg_dest_o == d.
  - Same-cycle set and clear of the same register: set wins, because a newer writer is outstanding.
  - flush_i clears all bits, but a reserve in the same cycle still sets its bit.
  - Bit 0 is always 0.
- busy_o = busy_r. It is registered, with no same-cycle reflection of reserve_i.
- Reset values: wr_reg_en_o 0, wr_reg_dest_o 0, wr_reg_data_o 0, busy_o 0, rr_ptr N_REQ-1.

## Timing
- Grant latency is 0 cycles: ready rises in the same cycle as valid when that requester wins.
- A transfer in cycle t produces wr_reg_en_o high in cycle t+1. The register file writes at the end of t+1, and its bypass serves readers during t+1.
- The busy bit for a write clears at the end of t+1, so busy_o reads 0 from t+2.
- Throughput is one write per cycle; back-to-back grants are allowed.
- With k requesters continuously valid, each one is granted exactly once every k cycles.
- rst_i mid-operation:
  - All state returns to reset values at that edge, and any in-flight write is dropped.
  - Requesters must re-present their data.

## Structure
- A shared package holds:
  - the register-index typedef (5 bits);
  - XLEN_DEFAULT;
  - NUM_ARCH_REGS = 32.
- The round-robin picker is one natural sub-module, rr_arbiter. It is parameterized on N, takes the request vector and pointer, and returns the one-hot grant and the granted index.
- The scoreboard and the write register stay inline.

## Test plan
- Reset: hold rst_i 2 cycles with all valids high. Required: ready all 0, wr_reg_en_o 0, busy_o 0.
- Single write: reserve x5, then req0 valid with dest 5, data 0xDEAD in cycle t. Required: busy_o[5]=1 before the write; ready0=1 in t; wr_reg_en_o=1 with dest 5, data 0xDEAD in t+1; busy_o[5]=0 in t+2.
- Fairness: all 3 valids held for 6 cycles. Required: grant order 0,1,2,0,1,2 with exactly one ready per cycle.
- x0 handling: reserve x0, then req1 with dest 0. Required: busy_o stays 0, req1 accepted, wr_reg_en_o stays 0.
- Set-beats-clear: a write to x7 is issuing (wr_reg_en_o high, dest 7) in the same cycle as reserve x7. Required: busy_o[7]=1 afterwards. With flush_i plus reserve x9 in one cycle, required: only bit 9 is set.
- Reset mid-transfer: rst_i in cycle t+1 after a grant in t. Required: wr_reg_en_o=0 and busy_o=0 in t+2.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice.
//   reg_idx_t     : architectural register index (x0..x31)
//   XLEN_DEFAULT  : default datapath width
//   NUM_ARCH_REGS : number of architectural registers tracked by the scoreboard
package regfile_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEFAULT  = 64;
  localparam int unsigned NUM_ARCH_REGS = 32;

  typedef logic [4:0] reg_idx_t;

  // One-hot mask selecting a single architectural register.
  function automatic logic [NUM_ARCH_REGS-1:0] reg_mask(input reg_idx_t r);
    logic [NUM_ARCH_REGS-1:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index of the most recently granted requester
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester (0 when no request)
// The search starts at ptr_i+1 and wraps, so the last winner has lowest priority.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among N_REQ writeback sources
// with round-robin arbitration and a valid/ready handshake, and keeps a
// 32-entry pending-write scoreboard for decode hazard stalls.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_valid_i/_dest_i/_data_i : per-requester write request
//   req_ready_o         : one-hot grant, transfer when valid & ready
//   reserve_i/_dest_i   : decode reserves a destination register
//   flush_i             : clears the scoreboard (same-cycle reserve survives)
//   wr_reg_en_o/_dest_o/_data_o : registered register-file write port
//   busy_o              : registered scoreboard, bit r = write to xr pending
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  logic [N_REQ-1:0][4:0]          req_dest_i,
  input  logic [N_REQ-1:0][XLEN-1:0]     req_data_i,
  output logic [N_REQ-1:0]               req_ready_o,
  input  logic                           reserve_i,
  input  logic [4:0]                     reserve_dest_i,
  input  logic                           flush_i,
  output logic                           wr_reg_en_o,
  output logic [4:0]                     wr_reg_dest_o,
  output logic [XLEN-1:0]                wr_reg_data_o,
  output logic [NUM_ARCH_REGS-1:0]       busy_o
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                     wr_en_q, wr_en_d;
  reg_idx_t                 wr_dest_q, wr_dest_d;
  logic [XLEN-1:0]          wr_data_q, wr_data_d;
  logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;
  reg_idx_t         gnt_dest;

  // Masking requests during reset keeps ready low without a separate gate.
  assign arb_req = rst_i ? '0 : req_valid_i;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (arb_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign xfer        = |gnt;
  assign gnt_dest    = req_dest_i[gnt_idx];

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = 1'b0;
    wr_dest_d = wr_dest_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      rr_ptr_d  = gnt_idx;
      wr_en_d   = (gnt_dest != '0);
      wr_dest_d = gnt_dest;
      wr_data_d = req_data_i[gnt_idx];
    end
  end

  // Clear is applied before set so a newer reservation of the register being
  // written in this cycle survives.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else if (wr_en_q) begin
      busy_d = busy_d & ~reg_mask(wr_dest_q);
    end
    if (reserve_i && (reserve_dest_i != '0)) begin
      busy_d = busy_d | reg_mask(reserve_dest_i);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= IDX_W'(N_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      wr_en_q   <= wr_en_d;
      wr_dest_q <= wr_dest_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_reg_en_o   = wr_en_q;
  assign wr_reg_dest_o = wr_dest_q;
  assign wr_reg_data_o = wr_data_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int N = 3;
  localparam int X = 64;

  typedef struct {
    logic        en;
    logic [4:0]  dest;
    logic [X-1:0] data;
  } wr_exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        valid;
  logic [N-1:0][4:0]   dst;
  logic [N-1:0][X-1:0] dat;
  logic [N-1:0]        ready;
  logic                res;
  logic [4:0]          resd;
  logic                fl;
  logic                wr_en;
  logic [4:0]          wr_dest;
  logic [X-1:0]        wr_data;
  logic [31:0]         busy;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  int          m_ptr;
  logic        m_en;
  logic [4:0]  m_dest;
  logic [X-1:0] m_data;
  logic [31:0] m_busy;
  wr_exp_t     sb_q[$];
  int          last_gnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(X)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (valid),
    .req_dest_i     (dst),
    .req_data_i     (dat),
    .req_ready_o    (ready),
    .reserve_i      (res),
    .reserve_dest_i (resd),
    .flush_i        (fl),
    .wr_reg_en_o    (wr_en),
    .wr_reg_dest_o  (wr_dest),
    .wr_reg_data_o  (wr_data),
    .busy_o         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic [N-1:0] eg;
    logic [31:0]  nb;
    wr_exp_t      e;
    int           gi;
    #1;
    eg = '0;
    gi = -1;
    if (!rst) begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (m_ptr + off) % N;
        if (gi < 0 && valid[c]) gi = c;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    last_gnt = gi;
    check_eq("ready", 64'(ready), 64'(eg));
    check_eq("busy", 64'(busy), 64'(m_busy));

    if (rst) begin
      m_ptr = N - 1; m_en = 1'b0; m_dest = '0; m_data = '0; m_busy = '0;
    end else begin
      nb = m_busy;
      if (fl) nb = '0;
      else if (m_en) nb[m_dest] = 1'b0;
      if (res && resd != 0) nb[resd] = 1'b1;
      m_busy = nb;
      if (gi >= 0) begin
        m_ptr  = gi;
        m_en   = (dst[gi] != 0);
        m_dest = dst[gi];
        m_data = dat[gi];
      end else begin
        m_en = 1'b0;
      end
    end
    e.en = m_en; e.dest = m_dest; e.data = m_data;
    sb_q.push_back(e);

    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("wr_en", 64'(wr_en), 64'(e.en));
      check_eq("wr_dest", 64'(wr_dest), 64'(e.dest));
      check_eq("wr_data", 64'(wr_data), 64'(e.data));
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; valid = '0; res = 1'b0; resd = '0; fl = 1'b0;
  endtask

  initial begin
    m_ptr = N - 1; m_en = 1'b0; m_dest = '0; m_data = '0; m_busy = '0;
    dst = '0; dat = '0;
    idle_inputs();
    @(negedge clk);

    // Reset with all valids high
    rst = 1'b1; valid = '1;
    tick(); tick();
    check_eq("rst_wr_en", 64'(wr_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    idle_inputs();

    // Single write to x5
    res = 1'b1; resd = 5'd5;
    tick();
    idle_inputs();
    check_eq("busy5_before", 64'(busy[5]), 64'd1);
    valid = 3'b001; dst[0] = 5'd5; dat[0] = 64'hDEAD;
    tick();
    check_eq("single_gnt", 64'(last_gnt), 64'd0);
    check_eq("single_en", 64'(wr_en), 64'd1);
    check_eq("single_data", 64'(wr_data), 64'hDEAD);
    idle_inputs();
    tick();
    check_eq("busy5_after", 64'(busy[5]), 64'd0);
    tick();

    // Fairness from reset: expect 0,1,2,0,1,2
    rst = 1'b1; tick(); idle_inputs();
    valid = '1;
    for (int i = 0; i < N; i++) begin
      dst[i] = 5'(10 + i); dat[i] = {$urandom, $urandom};
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("fair_order", 64'(last_gnt), 64'(k % N));
    end
    idle_inputs();

    // x0 handling
    res = 1'b1; resd = 5'd0;
    tick();
    idle_inputs();
    valid = 3'b010; dst[1] = 5'd0; dat[1] = 64'h1234;
    tick();
    check_eq("x0_gnt", 64'(last_gnt), 64'd1);
    check_eq("x0_en", 64'(wr_en), 64'd0);
    check_eq("x0_busy", 64'(busy), 64'd0);
    idle_inputs();

    // Set beats clear on x7
    res = 1'b1; resd = 5'd7;
    tick();
    idle_inputs();
    valid = 3'b100; dst[2] = 5'd7; dat[2] = 64'h7777;
    tick();
    idle_inputs();
    res = 1'b1; resd = 5'd7;   // write to x7 issuing this cycle
    tick();
    idle_inputs();
    tick();
    check_eq("set_beats_clr", 64'(busy[7]), 64'd1);
    fl = 1'b1; res = 1'b1; resd = 5'd9;
    tick();
    idle_inputs();
    check_eq("flush_resv", 64'(busy), 64'h200);
    tick();

    // Reset mid-transfer
    res = 1'b1; resd = 5'd3;
    tick();
    idle_inputs();
    valid = 3'b010; dst[1] = 5'd3; dat[1] = 64'hABCD;
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    idle_inputs();
    check_eq("midrst_en", 64'(wr_en), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);

    // Random traffic
    for (int k = 0; k < 60; k++) begin
      valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        dst[i] = 5'($urandom);
        dat[i] = {$urandom, $urandom};
      end
      res  = 1'($urandom);
      resd = 5'($urandom);
      fl   = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
